mem_access_unit: RTL

- Load/store unit directly upstream of the core's data memory; drives the data memory bus (addr, wrData, wrEnable; rdData back).
- Converts pipeline byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Word memory has no byte enables, so sub-word stores use a 2-cycle read-modify-write FSM. Loads are extracted, sign/zero-extended and registered.

---
 rtl/mem_access_unit_pkg.sv | 32 +++
 rtl/mem_lane_extract.sv | 25 ++
 rtl/mem_access_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

  // Encoding 3 is illegal on the pipeline side and behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic [1:0] align_lane(input mem_size_t size, input logic [1:0] lane);
    case (size)
      BYTE:    return lane;
      HALF:    return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Combinational lane select plus sign/zero extension for load data.
module mem_lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[{lane, 3'b000} +: 8];
    half_val = word[{lane[1], 4'b0000} +: 16];
    case (size)
      BYTE:    result = {{24{~is_unsigned & byte_val[7]}}, byte_val};
      HALF:    result = {{16{~is_unsigned & half_val[15]}}, half_val};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store unit in front of a word-only data memory; sub-word stores use RMW.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN adds o_misaligned and suppresses misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_store,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wrData,
  output logic                  o_mem_wrEnable,
  input  logic [DATA_WIDTH-1:0] i_mem_rdData
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic                  o_misaligned
`endif
);

  lsu_state_t            state;
  mem_size_t             req_size;
  logic [1:0]            req_lane;
  logic                  accept;
  logic                  misaligned_req;
  logic                  word_store;
  logic [DATA_WIDTH-1:0] load_value;
  logic [DATA_WIDTH-1:0] merged;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_lane;
  mem_size_t             lat_size;
  logic [15:0]           lat_data;

  assign req_size = decode_size(i_size);
  assign req_lane = align_lane(req_size, i_addr[1:0]);
  assign o_ready  = (state == IDLE);
  assign accept   = i_valid & o_ready;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misaligned_req = ((req_size == HALF) && i_addr[0]) ||
                          ((req_size == WORD) && (i_addr[1:0] != 2'b00));
`else
  assign misaligned_req = 1'b0;
`endif

  assign word_store = accept & i_store & (req_size == WORD) & ~misaligned_req;

  mem_lane_extract u_extract (
    .word        (i_mem_rdData),
    .lane        (req_lane),
    .size        (req_size),
    .is_unsigned (i_unsigned),
    .result      (load_value)
  );

  // Old word from memory with the latched lane(s) overwritten.
  always_comb begin
    merged = i_mem_rdData;
    if (lat_size == BYTE) begin
      merged[{lat_lane, 3'b000} +: 8] = lat_data[7:0];
    end else begin
      merged[{lat_lane[1], 4'b0000} +: 16] = lat_data;
    end
  end

  always_comb begin
    o_mem_addr     = (state == MERGE) ? lat_addr : i_addr[ADDR_WIDTH+1:2];
    o_mem_wrData   = (state == MERGE) ? merged : i_wrData;
    o_mem_wrEnable = ~i_reset & ((state == MERGE) | word_store);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      o_done   <= 1'b0;
      o_rdData <= '0;
      lat_addr <= '0;
      lat_lane <= 2'b00;
      lat_size <= BYTE;
      lat_data <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned_req || !i_store || (req_size == WORD)) begin
              o_done <= 1'b1;
              if (!misaligned_req && !i_store) begin
                o_rdData <= load_value;
              end
            end else begin
              lat_addr <= i_addr[ADDR_WIDTH+1:2];
              lat_lane <= req_lane;
              lat_size <= req_size;
              lat_data <= i_wrData[15:0];
              state    <= MERGE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_done <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= accept & misaligned_req;
    end
  end
`endif

endmodule
